// File: rtl/spy_playback_sequencer.sv
// rtl/spy_playback_sequencer.sv - load-then-replay sequencer for one spy buffer playback port
//
// Loads num_words host words into spy memory with the buffer in PLAYBACK_WRITE, holds WRITE
// for SETTLE_CYCLES, then replays the block with PLAYBACK_ONCE for num_passes passes
// (0 = until abort), dropping to NO_PLAYBACK for GAP_CYCLES between passes so the buffer
// rewinds its read pointer. End of pass is found by counting playback_enable_in.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   start, abort                 command pulses (abort wins over everything but reset)
//   num_words, num_passes        job size, latched on an accepted start
//   load_valid/load_data/        host load stream into spy memory
//   load_ready
//   playback_enable_in           one word replayed by the spy buffer
//   playback                     mode to the spy buffer
//   ram_write_enable_ext/        spy memory write strobe and data
//   ram_write_data_ext
//   busy, done, error            status (done/error are one-cycle pulses)
//   pass_count                   passes completed since the last start
module spy_playback_sequencer #(
  parameter int DATAWIDTH     = 64,
  parameter int MEMWIDTH      = 6,
  parameter int PASSWIDTH     = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int GAP_CYCLES    = 4,
  parameter int TIMEOUT       = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [MEMWIDTH:0]    num_words,
  input  logic [PASSWIDTH-1:0] num_passes,
  input  logic                 load_valid,
  input  logic [DATAWIDTH:0]   load_data,
  output logic                 load_ready,
  input  logic                 playback_enable_in,
  output logic [1:0]           playback,
  output logic                 ram_write_enable_ext,
  output logic [DATAWIDTH:0]   ram_write_data_ext,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [PASSWIDTH-1:0] pass_count
);

  localparam logic [1:0] NO_PLAYBACK    = 2'd0;
  localparam logic [1:0] PLAYBACK_ONCE  = 2'd1;
  localparam logic [1:0] PLAYBACK_WRITE = 2'd3;

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [GW-1:0]     GAP_LAST    = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0]     IDLE_LAST   = TW'(TIMEOUT - 1);
  localparam logic [MEMWIDTH:0] DEPTH       = {1'b1, {MEMWIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_PLAY, S_GAP, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           mode_d;
  logic                 err_d;
  logic [MEMWIDTH:0]    nw_q, word_cnt, play_cnt, word_inc, play_inc;
  logic [PASSWIDTH-1:0] np_q, pass_next;
  logic [SW-1:0]        settle_cnt;
  logic [GW-1:0]        gap_cnt;
  logic [TW-1:0]        idle_cnt;
  logic                 words_ok, beat, last_beat, pass_end, final_pass, timeout_hit;

  assign word_inc    = word_cnt + 1'b1;
  assign play_inc    = play_cnt + 1'b1;
  assign pass_next   = pass_count + 1'b1;
  assign words_ok    = (num_words != '0) && (num_words <= DEPTH);
  // load_ready is registered from the next state, so it already drops on the cycle after
  // the last beat; this keeps the strobe count at exactly num_words.
  assign beat        = (state_q == S_LOAD) && load_valid && load_ready;
  assign last_beat   = beat && (word_inc == nw_q);
  assign pass_end    = (state_q == S_PLAY) && playback_enable_in && (play_inc == nw_q);
  assign final_pass  = (np_q != '0) && (pass_next == np_q);
  assign timeout_hit = (state_q == S_PLAY) && !playback_enable_in && (idle_cnt == IDLE_LAST);

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (words_ok) state_d = S_LOAD;
          else          err_d   = 1'b1;
        end
      end
      S_LOAD:   if (last_beat) state_d = S_SETTLE;
      S_SETTLE: if (settle_cnt == SETTLE_LAST) state_d = S_PLAY;
      S_PLAY: begin
        if (pass_end) begin
          state_d = final_pass ? S_DONE : S_GAP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_GAP:    if (gap_cnt == GAP_LAST) state_d = S_PLAY;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      err_d   = 1'b0;
    end
    // Outputs are registered from the next state so the mode tracks the state exactly.
    unique case (state_d)
      S_LOAD, S_SETTLE: mode_d = PLAYBACK_WRITE;
      S_PLAY:           mode_d = PLAYBACK_ONCE;
      default:          mode_d = NO_PLAYBACK;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q              <= S_IDLE;
      playback             <= NO_PLAYBACK;
      load_ready           <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      error                <= 1'b0;
      ram_write_enable_ext <= 1'b0;
      ram_write_data_ext   <= '0;
      pass_count           <= '0;
      nw_q                 <= '0;
      np_q                 <= '0;
      word_cnt             <= '0;
      play_cnt             <= '0;
      settle_cnt           <= '0;
      gap_cnt              <= '0;
      idle_cnt             <= '0;
    end else begin
      state_q              <= state_d;
      playback             <= mode_d;
      load_ready           <= (state_d == S_LOAD);
      busy                 <= (state_d != S_IDLE);
      done                 <= (state_d == S_DONE);
      error                <= err_d;
      ram_write_enable_ext <= beat && !abort;
      if (beat && !abort) ram_write_data_ext <= load_data;

      if (state_q == S_IDLE && start && words_ok && !abort) begin
        nw_q       <= num_words;
        np_q       <= num_passes;
        word_cnt   <= '0;
        play_cnt   <= '0;
        pass_count <= '0;
      end
      if (beat) word_cnt <= word_inc;

      settle_cnt <= (state_q == S_SETTLE) ? settle_cnt + 1'b1 : '0;
      gap_cnt    <= (state_q == S_GAP)    ? gap_cnt + 1'b1    : '0;

      // The idle counter only runs while replaying and restarts on every replayed word.
      if (state_q == S_PLAY && playback_enable_in) begin
        play_cnt <= pass_end ? '0 : play_inc;
        idle_cnt <= '0;
        if (pass_end && !abort) pass_count <= pass_next;
      end else if (state_q == S_PLAY) begin
        idle_cnt <= idle_cnt + 1'b1;
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spy_playback_sequencer.sv
// tb/tb_spy_playback_sequencer.sv - randomized self-checking bench for spy_playback_sequencer
module tb_spy_playback_sequencer;
  localparam int DW = 64;
  localparam int MW = 6;
  localparam int PW = 8;
  localparam int SETTLE = 2;
  localparam int GAP = 4;
  localparam int TO = 1024;
  localparam logic [1:0] NOP = 2'd0;
  localparam logic [1:0] ONCE = 2'd1;
  localparam logic [1:0] WRITE = 2'd3;

  logic          clock = 1'b0;
  logic          reset, start, abort, load_valid, load_ready, playback_enable_in;
  logic [MW:0]   num_words;
  logic [PW-1:0] num_passes, pass_count;
  logic [DW:0]   load_data, ram_write_data_ext;
  logic [1:0]    playback;
  logic          ram_write_enable_ext, busy, done, error;

  int errors = 0;
  int checks = 0;
  logic [DW:0] load_q[$];

  always #5 clock = ~clock;

  spy_playback_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .num_words(num_words), .num_passes(num_passes),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .playback_enable_in(playback_enable_in), .playback(playback),
    .ram_write_enable_ext(ram_write_enable_ext), .ram_write_data_ext(ram_write_data_ext),
    .busy(busy), .done(done), .error(error), .pass_count(pass_count)
  );

  function automatic logic [DW:0] rand_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW:0];
  endfunction

  task automatic pulse_start(input int n, input int p);
    num_words  = n[MW:0];
    num_passes = p[PW-1:0];
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; load_valid = 1'b0; load_data = '0;
    playback_enable_in = 1'b0; num_words = '0; num_passes = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({playback, load_ready, busy, done, error, ram_write_enable_ext} !== 7'b0) begin
      errors++;
      $display("FAIL reset_status: got %b expected 0000000",
               {playback, load_ready, busy, done, error, ram_write_enable_ext});
    end
    checks++;
    if (pass_count !== '0) begin
      errors++; $display("FAIL reset_pass_count: got %0d expected 0", pass_count);
    end
    checks++;
    if (ram_write_data_ext !== '0) begin
      errors++; $display("FAIL reset_wdata: got %h expected 0", ram_write_data_ext);
    end
  endtask

  task automatic test_bad_num_words();
    int bad[2];
    bad[0] = 0;
    bad[1] = 65;
    for (int i = 0; i < 2; i++) begin
      pulse_start(bad[i], 1);
      checks++;
      if ({error, busy, playback} !== {1'b1, 1'b0, NOP}) begin
        errors++;
        $display("FAIL bad_words_%0d: error/busy/playback got %b expected 1000",
                 bad[i], {error, busy, playback});
      end
      @(negedge clock);
      checks++;
      if ({error, playback} !== {1'b0, NOP}) begin
        errors++;
        $display("FAIL bad_words_%0d_after: error/playback got %b expected 000",
                 bad[i], {error, playback});
      end
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_start(4, 1);
    load_valid = 1'b1;
    load_data  = rand_word();
    @(negedge clock);
    checks++;
    if ({busy, ram_write_enable_ext, playback} !== {2'b11, WRITE}) begin
      errors++;
      $display("FAIL mid_load_pre: busy/strobe/playback got %b expected 1111",
               {busy, ram_write_enable_ext, playback});
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({playback, load_ready, busy, ram_write_enable_ext} !== {NOP, 3'b000}) begin
      errors++;
      $display("FAIL mid_load_reset: playback/ready/busy/strobe got %b expected 00000",
               {playback, load_ready, busy, ram_write_enable_ext});
    end
    reset = 1'b0;
    load_valid = 1'b0;
    @(negedge clock);
  endtask

  // Drives one complete job from the bench-side data in load_q and checks the observed
  // trace: strobe contents, settle length, pass count, gap lengths and the done pulse.
  task automatic run_scenario(input string name, input int n, input int p,
                              input int vpct, input int epct);
    logic [DW:0] got_q[$];
    logic [1:0]  tr[$];
    int done_idx[$];
    int idx = 0, en_sent = 0, cyc = 0, last_strobe = -1;
    int k, settle_len, once_runs, gap_bad, last_once_end, data_bad;
    bit finished = 0, strobe_bad = 0, err_seen = 0;

    load_valid = 1'b0;
    playback_enable_in = 1'b0;
    pulse_start(n, p);
    while (!finished && cyc < 5000) begin
      tr.push_back(playback);
      if (ram_write_enable_ext) begin
        got_q.push_back(ram_write_data_ext);
        last_strobe = tr.size() - 1;
        if (playback != WRITE) strobe_bad = 1;
      end
      if (done) done_idx.push_back(tr.size() - 1);
      if (error) err_seen = 1;
      if (!busy) finished = 1;
      load_valid = (idx < n) && ($urandom_range(99) < vpct);
      load_data  = (idx < n) ? load_q[idx] : rand_word();
      if (load_valid && load_ready) idx++;
      if (playback == NOP) en_sent = 0;
      playback_enable_in = (playback == ONCE) && (en_sent < n) && ($urandom_range(99) < epct);
      if (playback_enable_in) en_sent++;
      cyc++;
      @(negedge clock);
    end
    load_valid = 1'b0;
    playback_enable_in = 1'b0;

    checks++;
    if (!finished || err_seen) begin
      errors++;
      $display("FAIL %s_complete: finished=%0d error_seen=%0d expected 1/0", name, finished, err_seen);
    end
    checks++;
    if (got_q.size() != n || strobe_bad) begin
      errors++;
      $display("FAIL %s_strobes: got %0d (outside WRITE=%0d) expected %0d", name, got_q.size(), strobe_bad, n);
    end
    data_bad = 0;
    for (int i = 0; i < got_q.size() && i < n; i++) if (got_q[i] !== load_q[i]) data_bad++;
    checks++;
    if (data_bad != 0) begin
      errors++; $display("FAIL %s_wdata: %0d words differ, expected 0", name, data_bad);
    end

    k = (last_strobe < 0) ? 0 : last_strobe;
    settle_len = 0;
    while (k < tr.size() && tr[k] == WRITE) begin k++; settle_len++; end
    checks++;
    if (settle_len != SETTLE) begin
      errors++; $display("FAIL %s_settle: got %0d WRITE cycles expected %0d", name, settle_len, SETTLE);
    end
    once_runs = 0; gap_bad = 0; last_once_end = -1;
    while (k < tr.size()) begin
      if (tr[k] == ONCE) begin
        while (k < tr.size() && tr[k] == ONCE) k++;
        once_runs++;
        last_once_end = k;
      end else begin
        int s = k;
        while (k < tr.size() && tr[k] != ONCE) begin
          if (tr[k] != NOP) gap_bad++;
          k++;
        end
        if (k < tr.size() && (k - s) != GAP) gap_bad++;
      end
    end
    checks++;
    if (once_runs != p || gap_bad != 0) begin
      errors++;
      $display("FAIL %s_passes: got %0d passes (%0d bad gaps) expected %0d", name, once_runs, gap_bad, p);
    end
    checks++;
    if (done_idx.size() != 1 || done_idx[0] != last_once_end) begin
      errors++;
      $display("FAIL %s_done: got %0d pulses expected 1 at end of last pass", name, done_idx.size());
    end
    checks++;
    if (pass_count !== p[PW-1:0] || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_final: pass_count=%0d busy=%b expected %0d/0", name, pass_count, busy, p);
    end
  endtask

  task automatic test_main_directed();
    load_q.delete();
    load_q.push_back(65'hA);
    load_q.push_back(65'hB);
    load_q.push_back(65'hC);
    load_q.push_back(65'hD);
    run_scenario("directed", 4, 2, 100, 100);
  endtask

  task automatic test_random_jobs();
    for (int r = 0; r < 5; r++) begin
      int n = $urandom_range(1, 10);
      load_q.delete();
      for (int i = 0; i < n; i++) load_q.push_back(rand_word());
      run_scenario($sformatf("rand%0d", r), n, $urandom_range(1, 3),
                   $urandom_range(40, 100), $urandom_range(30, 100));
    end
    load_q.delete();
    for (int i = 0; i < 64; i++) load_q.push_back(rand_word());
    run_scenario("full_depth", 64, 1, 80, 90);
  endtask

  task automatic test_load_overrun();
    int strobes = 0, readys = 0;
    pulse_start(3, 1);
    for (int i = 0; i < 8; i++) begin
      if (ram_write_enable_ext) strobes++;
      if (load_ready) readys++;
      load_valid = (i < 6);
      load_data  = rand_word();
      @(negedge clock);
    end
    checks++;
    if (strobes != 3 || readys != 3) begin
      errors++;
      $display("FAIL overrun: strobes=%0d ready_cycles=%0d expected 3/3", strobes, readys);
    end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL overrun_abort: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_infinite_abort();
    int passes = 0, beats = 0, sent = 0, cyc = 0;
    logic [1:0] prev = WRITE;
    bit done_seen = 0;
    pulse_start(2, 0);
    while (passes < 5 && cyc < 2000) begin
      if (done) done_seen = 1;
      if (prev == ONCE && playback == NOP) begin
        passes++;
        checks++;
        if (pass_count !== passes[PW-1:0]) begin
          errors++; $display("FAIL inf_pass_count: got %0d expected %0d", pass_count, passes);
        end
      end
      if (playback == NOP) sent = 0;
      prev = playback;
      load_valid = (beats < 2);
      load_data  = rand_word();
      if (load_valid && load_ready) beats++;
      playback_enable_in = (playback == ONCE) && (sent < 2) && ($urandom_range(1) == 1);
      if (playback_enable_in) sent++;
      cyc++;
      @(negedge clock);
    end
    load_valid = 1'b0;
    playback_enable_in = 1'b0;
    cyc = 0;
    while (playback != ONCE && cyc < 50) begin cyc++; @(negedge clock); end
    playback_enable_in = 1'b1;
    @(negedge clock);
    playback_enable_in = 1'b0;
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    checks++;
    if (passes != 5 || done_seen) begin
      errors++; $display("FAIL inf_passes: got %0d passes done_seen=%0d expected 5/0", passes, done_seen);
    end
    checks++;
    if ({playback, busy, done, load_ready, ram_write_enable_ext} !== {NOP, 4'b0000}) begin
      errors++;
      $display("FAIL inf_abort: playback/busy/done/ready/strobe got %b expected 000000",
               {playback, busy, done, load_ready, ram_write_enable_ext});
    end
    checks++;
    if (pass_count !== 8'd5) begin
      errors++; $display("FAIL inf_abort_count: got %0d expected 5", pass_count);
    end
  endtask

  task automatic test_timeout();
    int c = 0, cnt = 0;
    pulse_start(1, 1);
    load_valid = 1'b1;
    load_data  = rand_word();
    @(negedge clock);
    load_valid = 1'b0;
    while (playback != ONCE && c < 20) begin c++; @(negedge clock); end
    while (playback == ONCE && cnt < TO + 100) begin cnt++; @(negedge clock); end
    checks++;
    if (cnt != TO) begin
      errors++; $display("FAIL timeout_len: got %0d PLAY cycles expected %0d", cnt, TO);
    end
    checks++;
    if ({error, busy, playback} !== {1'b1, 1'b0, NOP}) begin
      errors++;
      $display("FAIL timeout_status: error/busy/playback got %b expected 1000", {error, busy, playback});
    end
    @(negedge clock);
    checks++;
    if (error !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: error got %b expected 0", error);
    end
  endtask

  initial begin
    test_reset();
    test_bad_num_words();
    test_reset_mid_load();
    test_main_directed();
    test_random_jobs();
    test_load_overrun();
    test_infinite_abort();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
